id_ex_stage: RTL

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/mips_pkg.sv | 44 ++++
 rtl/fwd_mux.sv | 35 +++
 rtl/id_ex_stage.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared widths, ALU operation codes and the ID/EX slot record for the MIPS pipeline.
package mips_pkg;

    localparam int unsigned DataW = 32;
    localparam int unsigned RegW  = 5;
    localparam int unsigned ImmW  = 16;
    localparam int unsigned OpW   = 4;

    typedef enum logic [OpW-1:0] {
        AluAnd = 4'b0000,
        AluOr  = 4'b0001,
        AluAdd = 4'b0010,
        AluXor = 4'b0011,
        AluSub = 4'b0110,
        AluSlt = 4'b0111,
        AluNor = 4'b1100
    } alu_op_e;

    typedef enum logic {
        StEmpty,
        StFull
    } slot_state_e;

    typedef struct packed {
        logic [DataW-1:0] rs_data;
        logic [DataW-1:0] rt_data;
        logic [ImmW-1:0]  imm;
        logic [RegW-1:0]  rs;
        logic [RegW-1:0]  rt;
        logic [RegW-1:0]  wr_reg;
        logic [OpW-1:0]   operation;
        logic             alu_src;
        logic             sign_ext;
        logic             reg_write;
        logic             mem_read;
        logic             mem_write;
    } id_ex_t;

    function automatic logic [DataW-1:0] extend_imm(input logic [ImmW-1:0] imm,
                                                    input logic            sign_ext);
        return sign_ext ? {{(DataW-ImmW){imm[ImmW-1]}}, imm} : {{(DataW-ImmW){1'b0}}, imm};
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding select: MEM result beats WB result beats captured data; $0 never forwarded.
// Selection logic exists only when MIPS_FORWARD_EN is defined; otherwise data passes through.
module fwd_mux
    import mips_pkg::*;
(
    input  logic [RegW-1:0]  reg_num,
    input  logic [DataW-1:0] reg_data,
    input  logic             mem_reg_write,
    input  logic [RegW-1:0]  mem_wr_reg,
    input  logic [DataW-1:0] mem_result,
    input  logic             wb_reg_write,
    input  logic [RegW-1:0]  wb_wr_reg,
    input  logic [DataW-1:0] wb_result,
    output logic [DataW-1:0] fwd_data
);

`ifdef MIPS_FORWARD_EN
    always_comb begin
        fwd_data = reg_data;
        if (reg_num != '0) begin
            if (mem_reg_write && (mem_wr_reg == reg_num)) begin
                fwd_data = mem_result;
            end else if (wb_reg_write && (wb_wr_reg == reg_num)) begin
                fwd_data = wb_result;
            end
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{reg_num, mem_reg_write, mem_wr_reg, mem_result,
                          wb_reg_write, wb_wr_reg, wb_result};
    assign fwd_data   = reg_data;
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: one-slot buffer with load-use stall, flush and operand forwarding.
// Define MIPS_FORWARD_EN to enable forwarding; without it every RAW hazard stalls instead.
module id_ex_stage
    import mips_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    output logic             id_ready,
    input  logic [DataW-1:0] id_rs_data,
    input  logic [DataW-1:0] id_rt_data,
    input  logic [ImmW-1:0]  id_imm,
    input  logic [RegW-1:0]  id_rs,
    input  logic [RegW-1:0]  id_rt,
    input  logic [RegW-1:0]  id_wr_reg,
    input  logic [OpW-1:0]   id_operation,
    input  logic             id_alu_src,
    input  logic             id_sign_ext,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             mem_reg_write,
    input  logic [RegW-1:0]  mem_wr_reg,
    input  logic [DataW-1:0] mem_result,
    input  logic             wb_reg_write,
    input  logic [RegW-1:0]  wb_wr_reg,
    input  logic [DataW-1:0] wb_result,
    input  logic             flush,
    input  logic             ex_ready,
    output logic             ex_valid,
    output logic [DataW-1:0] SrcA,
    output logic [DataW-1:0] SrcB,
    output logic [OpW-1:0]   operation,
    output logic [RegW-1:0]  ex_wr_reg,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic [DataW-1:0] ex_store_data,
    output logic             hazard_stall
);

    slot_state_e      state_q, state_d;
    id_ex_t           slot_q, slot_d;
    logic             transfer;
    logic             ex_hit;
    logic [DataW-1:0] rs_fwd, rt_fwd;

    assign ex_valid = (state_q == StFull);

    always_comb begin
        ex_hit = ex_valid && (slot_q.wr_reg != '0) &&
                 ((slot_q.wr_reg == id_rs) || (slot_q.wr_reg == id_rt));
`ifdef MIPS_FORWARD_EN
        hazard_stall = id_valid && ex_hit && slot_q.mem_read;
`else
        // No bypass: any pending write from EX or MEM to a source register must drain first.
        hazard_stall = id_valid &&
                       ((ex_hit && (slot_q.reg_write || slot_q.mem_read)) ||
                        (mem_reg_write && (mem_wr_reg != '0) &&
                         ((mem_wr_reg == id_rs) || (mem_wr_reg == id_rt))));
`endif
    end

    assign id_ready = (ex_ready || !ex_valid) && !hazard_stall;
    assign transfer = id_valid && id_ready;

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        if (flush) begin
            state_d = StEmpty;
        end else if (transfer) begin
            state_d          = StFull;
            slot_d.rs_data   = id_rs_data;
            slot_d.rt_data   = id_rt_data;
            slot_d.imm       = id_imm;
            slot_d.rs        = id_rs;
            slot_d.rt        = id_rt;
            slot_d.wr_reg    = id_wr_reg;
            slot_d.operation = id_operation;
            slot_d.alu_src   = id_alu_src;
            slot_d.sign_ext  = id_sign_ext;
            slot_d.reg_write = id_reg_write;
            slot_d.mem_read  = id_mem_read;
            slot_d.mem_write = id_mem_write;
        end else if (ex_ready) begin
            // Drained with nothing to replace it (includes the load-use bubble).
            state_d = StEmpty;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StEmpty;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
        end
    end

    fwd_mux u_fwd_rs (
        .reg_num       (slot_q.rs),
        .reg_data      (slot_q.rs_data),
        .mem_reg_write (mem_reg_write),
        .mem_wr_reg    (mem_wr_reg),
        .mem_result    (mem_result),
        .wb_reg_write  (wb_reg_write),
        .wb_wr_reg     (wb_wr_reg),
        .wb_result     (wb_result),
        .fwd_data      (rs_fwd)
    );

    fwd_mux u_fwd_rt (
        .reg_num       (slot_q.rt),
        .reg_data      (slot_q.rt_data),
        .mem_reg_write (mem_reg_write),
        .mem_wr_reg    (mem_wr_reg),
        .mem_result    (mem_result),
        .wb_reg_write  (wb_reg_write),
        .wb_wr_reg     (wb_wr_reg),
        .wb_result     (wb_result),
        .fwd_data      (rt_fwd)
    );

    assign SrcA          = rs_fwd;
    assign SrcB          = slot_q.alu_src ? extend_imm(slot_q.imm, slot_q.sign_ext) : rt_fwd;
    assign ex_store_data = rt_fwd;
    assign operation     = slot_q.operation;
    assign ex_wr_reg     = slot_q.wr_reg;
    assign ex_reg_write  = ex_valid && slot_q.reg_write;
    assign ex_mem_read   = ex_valid && slot_q.mem_read;
    assign ex_mem_write  = ex_valid && slot_q.mem_write;

endmodule
